// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg -- shared types and constants for the RV32I multicycle controller.
//
// Contents: FSM state enum, ALUOp encodings, ALUControl / ResultSrc /
// ALUSrcA / ALUSrcB / ImmSrc constants, opcode constants and the
// combinational immediate-format decode.
//
// Optional feature macro: RV_MC_JALR_EN (adds the JALR_ADR state).
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
`ifdef RV_MC_JALR_EN
        , S_JALR_ADR = 4'd12
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Immediate format from the opcode alone; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/rv_mc_alu_dec.sv
// rv_mc_alu_dec -- combinational ALUControl decode.
//
// Ports:
//   alu_op      in  : ALUOp class (add / sub / funct) from the controller FSM
//   funct3      in  : instruction [14:12]
//   op5         in  : instruction [5] (distinguishes R-type from I-type)
//   funct7b5    in  : instruction [30]
//   alu_control out : ALUControl, zero-extended to ALUC_W bits
module rv_mc_alu_dec
    import rv_mc_pkg::*;
#(
    parameter int ALUC_W = 3
) (
    input  aluop_t            alu_op,
    input  logic [2:0]        funct3,
    input  logic              op5,
    input  logic              funct7b5,
    output logic [ALUC_W-1:0] alu_control
);

    logic [2:0] ctrl;

    always_comb begin
        ctrl = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: ctrl = ALUC_ADD;
            ALUOP_SUB: ctrl = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 means sub only for register-register ops;
                    // for addi it is just an immediate bit.
                    3'b000:  ctrl = (op5 && funct7b5) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  ctrl = ALUC_SLT;
                    3'b110:  ctrl = ALUC_OR;
                    3'b111:  ctrl = ALUC_AND;
                    default: ctrl = ALUC_ADD;
                endcase
            end
            default: ctrl = ALUC_ADD;
        endcase
    end

    assign alu_control = ALUC_W'(ctrl);

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl -- Moore FSM sequencing one RV32I instruction over the
// shared-ALU, unified-memory multicycle datapath.
//
// Parameters: MEM_WAIT (0..15 extra memory cycles in FETCH/MEMREAD),
//             ALUC_W (ALUControl width, upper bits driven 0).
// Optional feature macro: RV_MC_JALR_EN (opcode 1100111 runs
//             DECODE -> JALR_ADR -> JAL -> ALUWB instead of trapping).
//
// Ports:
//   clk, reset (sync, active-high)           in
//   op[6:0], funct3[2:0], funct7b5, Zero     in  : IR fields and ALU flag
//   PCWrite, AdrSrc, MemWrite, IRWrite       out : datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc [1:0] out : datapath mux selects
//   ALUControl[ALUC_W-1:0]                   out : ALU operation
//   RegWrite, Illegal                        out : register write, in TRAP
//   dbg_state                                out : current FSM state
module rv_multicycle_ctrl
    import rv_mc_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int ALUC_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              RegWrite,
    output logic              Illegal,
    output state_t            dbg_state
);

    localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    state_t state, state_next, out_state;
    aluop_t alu_op;
    logic   wait_done, pc_update, branch;

    // Memory wait counter: cleared whenever the state changes, saturates at
    // MEM_WAIT. Only FETCH and MEMREAD look at it.
    generate
        if (MEM_WAIT > 0) begin : g_wait
            logic [WAIT_W-1:0] wait_cnt;
            always_ff @(posedge clk) begin
                if (reset || (state_next != state)) begin
                    wait_cnt <= '0;
                end else if (!wait_done) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
            end
            assign wait_done = (wait_cnt == WAIT_W'(MEM_WAIT));
        end else begin : g_nowait
            assign wait_done = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:   state_next = wait_done ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECUTER;
                    OP_I:         state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
`ifdef RV_MC_JALR_EN
                    OP_JALR:      state_next = S_JALR_ADR;
`endif
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_next = wait_done ? S_MEMWB : S_MEMREAD;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_JAL:      state_next = S_ALUWB;
`ifdef RV_MC_JALR_EN
            S_JALR_ADR: state_next = S_JAL;
`endif
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // While reset is high the outputs show FETCH; the FETCH write strobes
    // are additionally gated by reset so nothing is written.
    assign out_state = reset ? S_FETCH : state;

    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        pc_update = 1'b0;
        branch    = 1'b0;
        case (out_state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = wait_done && !reset;
                pc_update = wait_done && !reset;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
`ifdef RV_MC_JALR_EN
            S_JALR_ADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
`endif
            S_TRAP: Illegal = 1'b1;
            default: ;
        endcase
    end

    assign PCWrite   = pc_update | (branch & Zero);
    assign ImmSrc    = imm_src_of(op);
    assign dbg_state = state;

    rv_mc_alu_dec #(.ALUC_W(ALUC_W)) u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl -- bench for rv_multicycle_ctrl.
// Two instances (MEM_WAIT=0/ALUC_W=3 and MEM_WAIT=2/ALUC_W=4); one is active
// at a time while the other is held in reset. The reference model describes
// each instruction as a list of phases whose length follows from the
// instruction cycle counts, and the scoreboard queue holds the expected
// outputs of every cycle.
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;

  localparam int OW = 18;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] imm;
    logic [2:0] aluc;
    logic       aluc_hi;
    logic       regw;
    logic       ill;
  } outs_t;

  // phases of an instruction
  localparam int PH_FETCH = 0, PH_FETCH_LAST = 1, PH_DECODE = 2, PH_MEMADR = 3,
                 PH_MEMREAD = 4, PH_MEMWB = 5, PH_MEMWRITE = 6, PH_EXER = 7,
                 PH_EXEI = 8, PH_ALUWB = 9, PH_BEQ = 10, PH_JAL = 11,
                 PH_JALRADR = 12, PH_TRAP = 13, PH_RESET = 14;
  // instruction classes
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5,
                 C_JALR = 6, C_TRAP = 7;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset0, reset2, sel;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, done;

  logic       pcw0, adr0, memw0, irw0, regw0, ill0;
  logic [1:0] res0, a0, b0, imm0;
  logic [2:0] aluc0;
  logic       pcw2, adr2, memw2, irw2, regw2, ill2;
  logic [1:0] res2, a2, b2, imm2;
  logic [3:0] aluc2;
  rv_mc_pkg::state_t dbg0, dbg2;

  rv_multicycle_ctrl #(.MEM_WAIT(0), .ALUC_W(3)) dut0 (
    .clk(clk), .reset(reset0), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(memw0),
    .IRWrite(irw0), .ResultSrc(res0), .ALUSrcA(a0), .ALUSrcB(b0),
    .ImmSrc(imm0), .ALUControl(aluc0), .RegWrite(regw0), .Illegal(ill0),
    .dbg_state(dbg0)
  );

  rv_multicycle_ctrl #(.MEM_WAIT(2), .ALUC_W(4)) dut2 (
    .clk(clk), .reset(reset2), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(zero), .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(memw2),
    .IRWrite(irw2), .ResultSrc(res2), .ALUSrcA(a2), .ALUSrcB(b2),
    .ImmSrc(imm2), .ALUControl(aluc2), .RegWrite(regw2), .Illegal(ill2),
    .dbg_state(dbg2)
  );

  outs_t act;
  always_comb begin
    act = '0;
    if (sel) begin
      act.pcw = pcw2; act.adr = adr2; act.memw = memw2; act.irw = irw2;
      act.res = res2; act.a = a2; act.b = b2; act.imm = imm2;
      act.aluc = aluc2[2:0]; act.aluc_hi = aluc2[3];
      act.regw = regw2; act.ill = ill2;
    end else begin
      act.pcw = pcw0; act.adr = adr0; act.memw = memw0; act.irw = irw0;
      act.res = res0; act.a = a0; act.b = b0; act.imm = imm0;
      act.aluc = aluc0; act.aluc_hi = 1'b0;
      act.regw = regw0; act.ill = ill0;
    end
  end

  // ---------------- reference model ----------------
  function automatic int op_class(input logic [6:0] o);
    case (o)
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b1100011: return C_BEQ;
      7'b1101111: return C_JAL;
`ifdef RV_MC_JALR_EN
      7'b1100111: return C_JALR;
`endif
      default:    return C_TRAP;
    endcase
  endfunction

  // cycles from first FETCH cycle to the last cycle of the instruction
  // (for traps: through DECODE only)
  function automatic int seq_len(input logic [6:0] o, input int w);
    case (op_class(o))
      C_LW:    return 5 + 2 * w;
      C_SW:    return 4 + w;
      C_R:     return 4 + w;
      C_I:     return 4 + w;
      C_BEQ:   return 3 + w;
      C_JAL:   return 4 + w;
      C_JALR:  return 5 + w;
      default: return 2 + w;
    endcase
  endfunction

  function automatic int phase_at(input logic [6:0] o, input int w, input int idx);
    int k;
    if (idx < w) return PH_FETCH;
    if (idx == w) return PH_FETCH_LAST;
    k = idx - w - 1;
    if (k == 0) return PH_DECODE;
    case (op_class(o))
      C_LW:    return (k == 1) ? PH_MEMADR : ((k <= w + 2) ? PH_MEMREAD : PH_MEMWB);
      C_SW:    return (k == 1) ? PH_MEMADR : PH_MEMWRITE;
      C_R:     return (k == 1) ? PH_EXER : PH_ALUWB;
      C_I:     return (k == 1) ? PH_EXEI : PH_ALUWB;
      C_BEQ:   return PH_BEQ;
      C_JAL:   return (k == 1) ? PH_JAL : PH_ALUWB;
      C_JALR:  return (k == 1) ? PH_JALRADR : ((k == 2) ? PH_JAL : PH_ALUWB);
      default: return PH_TRAP;
    endcase
  endfunction

  function automatic logic [2:0] alu_funct(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic outs_t outs_of(input int ph, input logic [6:0] o,
                                    input logic [2:0] f3, input logic f7, input logic z);
    outs_t r;
    r = '0;
    r.imm = imm_of(o);
    case (ph)
      PH_FETCH, PH_RESET: begin r.b = 2'b10; r.res = 2'b10; end
      PH_FETCH_LAST: begin r.b = 2'b10; r.res = 2'b10; r.irw = 1'b1; r.pcw = 1'b1; end
      PH_DECODE:   begin r.a = 2'b01; r.b = 2'b01; end
      PH_MEMADR:   begin r.a = 2'b10; r.b = 2'b01; end
      PH_MEMREAD:  r.adr = 1'b1;
      PH_MEMWB:    begin r.res = 2'b01; r.regw = 1'b1; end
      PH_MEMWRITE: begin r.adr = 1'b1; r.memw = 1'b1; end
      PH_EXER:     begin r.a = 2'b10; r.aluc = alu_funct(o, f3, f7); end
      PH_EXEI:     begin r.a = 2'b10; r.b = 2'b01; r.aluc = alu_funct(o, f3, f7); end
      PH_ALUWB:    r.regw = 1'b1;
      PH_BEQ:      begin r.a = 2'b10; r.aluc = 3'b001; r.pcw = z; end
      PH_JAL:      begin r.a = 2'b01; r.b = 2'b10; r.pcw = 1'b1; end
      PH_JALRADR:  begin r.a = 2'b10; r.b = 2'b01; end
      PH_TRAP:     r.ill = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] actv, input logic [31:0] expv);
    n_checks++;
    if (actv !== expv) begin
      n_errors++;
      $display("FAIL %s t=%0t sel=%0d state=%s actual=%h expected=%h", name, $time, sel,
               sel ? dbg2.name() : dbg0.name(), actv, expv);
    end
  endtask

  initial begin : compare
    outs_t e;
    logic [5:0] irw_mask, memw_mask;
    // hand-computed values that pin the model
    check("pin_len_lw_w0", seq_len(7'b0000011, 0), 5);
    check("pin_len_sw_w2", seq_len(7'b0100011, 2), 6);
    check("pin_len_beq_w0", seq_len(7'b1100011, 0), 3);
    check("pin_len_lw_w2", seq_len(7'b0000011, 2), 9);
    e = outs_of(phase_at(7'b0000011, 0, 4), 7'b0000011, 3'b010, 1'b0, 1'b0);
    check("pin_lw_wb", {29'd0, e.regw, e.res}, 32'b101);
    e = outs_of(phase_at(7'b0000011, 0, 3), 7'b0000011, 3'b010, 1'b0, 1'b0);
    check("pin_lw_rd", {30'd0, e.regw, e.adr}, 32'b01);
    irw_mask = '0;
    memw_mask = '0;
    for (int i = 0; i < 6; i++) begin
      e = outs_of(phase_at(7'b0100011, 2, i), 7'b0100011, 3'b010, 1'b0, 1'b0);
      irw_mask[i] = e.irw;
      memw_mask[i] = e.memw;
    end
    check("pin_sw_irw", irw_mask, 6'b000100);
    check("pin_sw_memw", memw_mask, 6'b100000);
    e = outs_of(phase_at(7'b1100011, 0, 2), 7'b1100011, 3'b000, 1'b0, 1'b1);
    check("pin_beq_z1", e.pcw, 1);
    e = outs_of(phase_at(7'b1100011, 0, 2), 7'b1100011, 3'b000, 1'b0, 1'b0);
    check("pin_beq_z0", e.pcw, 0);
    check("pin_alu_sub", alu_funct(7'b0110011, 3'b000, 1'b1), 3'b001);
    check("pin_alu_addi", alu_funct(7'b0010011, 3'b000, 1'b1), 3'b000);
    check("pin_alu_xor", alu_funct(7'b0110011, 3'b100, 1'b1), 3'b000);
    check("pin_alu_slt", alu_funct(7'b0110011, 3'b010, 1'b0), 3'b101);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cycle_outputs", {14'd0, act}, {14'd0, e});
      end
      if (done) begin
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset(input logic v);
    if (sel) reset2 = v;
    else reset0 = v;
  endtask

  task automatic do_reset(input int n);
    set_reset(1'b1);
    for (int i = 0; i < n; i++) exp_q.push_back(outs_of(PH_RESET, op, funct3, funct7b5, zero));
    repeat (n) step();
    set_reset(1'b0);
  endtask

  task automatic use_dut(input logic s);
    reset0 = 1'b1;
    reset2 = 1'b1;
    sel = s;
    do_reset(2);
  endtask

  // abort_at >= 0 asserts reset in that cycle of the instruction;
  // hold is the number of TRAP cycles for illegal opcodes
  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input int abort_at, input int hold);
    int w, len, total, n;
    logic trap, aborted;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    w = sel ? 2 : 0;
    len = seq_len(o, w);
    trap = (op_class(o) == C_TRAP);
    total = len + (trap ? hold : 0);
    aborted = (abort_at >= 0) && (abort_at < total);
    n = aborted ? abort_at : total;
    for (int i = 0; i < n; i++) begin
      if (i < len) exp_q.push_back(outs_of(phase_at(o, w, i), o, f3, f7, z));
      else exp_q.push_back(outs_of(PH_TRAP, o, f3, f7, z));
    end
    repeat (n) step();
    if (aborted || trap) do_reset($urandom_range(1, 2));
  endtask

  task automatic run_random();
    logic [6:0] legal [7];
    logic [6:0] bad [4];
    int r, abort_at;
    logic [6:0] o;
    legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1100111};
    bad = '{7'b1110011, 7'b0110111, 7'b0010111, 7'b0000000};
    r = $urandom_range(0, 9);
    abort_at = -1;
    if (r <= 6) o = legal[r];
    else if (r == 7) o = bad[$urandom_range(0, 3)];
    else if (r == 8) begin
      o = legal[$urandom_range(0, 6)];
      abort_at = $urandom_range(0, 8);
    end else o = 7'b0110011;
    run(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
        abort_at, $urandom_range(1, 6));
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    sel = 1'b0; reset0 = 1'b1; reset2 = 1'b1; done = 1'b0;
    op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0;
    step();
    do_reset(2);
    // MEM_WAIT = 0
    run(7'b0000011, 3'b010, 1'b0, 1'b0, -1, 0);   // lw
    run(7'b0110011, 3'b000, 1'b1, 1'b0, -1, 0);   // sub
    run(7'b0010011, 3'b000, 1'b1, 1'b0, -1, 0);   // addi, funct7b5 ignored
    run(7'b0110011, 3'b100, 1'b1, 1'b0, -1, 0);   // xor -> add
    run(7'b0110011, 3'b111, 1'b0, 1'b0, -1, 0);   // and
    run(7'b0010011, 3'b110, 1'b0, 1'b0, -1, 0);   // ori
    run(7'b1100011, 3'b000, 1'b0, 1'b1, -1, 0);   // beq taken
    run(7'b1100011, 3'b000, 1'b0, 1'b0, -1, 0);   // beq not taken
    run(7'b1101111, 3'b000, 1'b0, 1'b0, -1, 0);   // jal
    run(7'b1100111, 3'b000, 1'b0, 1'b0, -1, 3);   // jalr (trap without macro)
    run(7'b1110011, 3'b000, 1'b0, 1'b0, -1, 10);  // ecall -> trap, then reset
    run(7'b0100011, 3'b010, 1'b0, 1'b0, -1, 0);   // sw
    // MEM_WAIT = 2
    use_dut(1'b1);
    run(7'b0100011, 3'b010, 1'b0, 1'b0, -1, 0);   // sw, 6 cycles
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 5, 0);    // reset during MEMWRITE
    run(7'b0000011, 3'b010, 1'b0, 1'b0, -1, 0);   // lw, 9 cycles
    run(7'b1100011, 3'b000, 1'b0, 1'b1, -1, 0);
    run(7'b1100011, 3'b000, 1'b0, 1'b0, -1, 0);
    run(7'b0000011, 3'b010, 1'b0, 1'b0, 2, 0);    // reset in last FETCH cycle
    for (int blk = 0; blk < 4; blk++) begin
      use_dut(blk[0]);
      for (int i = 0; i < 25; i++) run_random();
    end
    done = 1'b1;
  end

endmodule
